// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {instruction, address} pairs.
// Optional occupancy output is enabled by defining INSTR_QUEUE_COUNT_EN.
module instr_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_address,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_address,
    input  logic        out_ready,
    input  logic        flush
`ifdef INSTR_QUEUE_COUNT_EN
   ,output logic [PTR_W:0] count
`endif
);

    localparam int unsigned ENTRY_W = 64;
    localparam int unsigned CNT_W   = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occupancy;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Handshake qualifiers; flush cancels both transfers.
    always_comb begin
        in_ready  = (occupancy != CNT_W'(DEPTH));
        out_valid = (occupancy != CNT_W'(0));
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                occupancy <= occupancy + CNT_W'(1);
            else if (pop && !push)
                occupancy <= occupancy - CNT_W'(1);
        end
    end

    // Storage is deliberately unreset; entries are only visible while counted.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {in_instruction, in_address};
    end

    always_comb begin
        head            = mem[rd_ptr];
        out_instruction = 32'h0;
        out_address     = 32'h0;
        if (out_valid) begin
            out_instruction = head[63:32];
            out_address     = head[31:0];
        end
    end

`ifdef INSTR_QUEUE_COUNT_EN
    assign count = occupancy;
`endif

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, at least 2.
REQ-002 The block SHALL have parameter PTR_W, default 2, set to log2(DEPTH) and used as the pointer width.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-006 Port in_instruction, input, 32 bits: instruction word from the fetch stage.
REQ-007 Port in_address, input, 32 bits: address of that instruction.
REQ-008 Port in_ready, output, 1 bit: the queue can accept an entry this cycle.
REQ-009 Port out_valid, output, 1 bit: head entry is valid for the decode stage.
REQ-010 Port out_instruction, output, 32 bits: instruction word of the head entry.
REQ-011 Port out_address, output, 32 bits: address of the head entry.
REQ-012 Port out_ready, input, 1 bit: the decode stage consumes the head entry this cycle.
REQ-013 Port flush, input, 1 bit: discard all entries (taken jump or redirect).

Function
REQ-014 Push SHALL occur on a rising edge when in_valid=1, in_ready=1 and flush=0; the pair {instruction, address} is written at the write pointer.
REQ-015 Pop SHALL occur on a rising edge when out_valid=1, out_ready=1 and flush=0; the read pointer advances.
REQ-016 Occupancy count SHALL be PTR_W+1 bits wide; it increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
REQ-017 in_ready SHALL equal (count != DEPTH), combinational from state only; it SHALL NOT depend on out_ready, so there is no push-through when full.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 out_instruction and out_address SHALL show the entry at the read pointer when out_valid=1, and SHALL be 32'h0 when out_valid=0.
REQ-020 Latency SHALL be exactly 1 cycle: an entry pushed at edge N is visible on the outputs after edge N if the queue was empty.
REQ-021 The read and write pointers SHALL wrap modulo DEPTH, and ordering SHALL be strict FIFO across the wrap.
REQ-022 Flush SHALL take priority over push and pop: on the edge with flush=1, count and both pointers go to 0, and any concurrent push or pop is discarded.
REQ-023 After a flush edge: out_valid=0 and in_ready=1.
REQ-024 Empty with in_valid=1 and out_ready=1 SHALL push only; no pop occurs that cycle.
REQ-025 Full with out_ready=1 SHALL pop only; in_ready stays 0 that cycle.
REQ-026 Storage SHALL consist of DEPTH registers of 64 bits each, holding {instruction, address}.

Reset
REQ-027 While reset=0, regardless of clock: count=0, both pointers=0, out_valid=0, in_ready=1, out_instruction=0, out_address=0.
REQ-028 Assertion of reset mid-operation SHALL clear state immediately and drop all queued entries.
REQ-029 Storage contents SHALL NOT be reset; they are unobservable while empty.
REQ-030 Release of reset SHALL take effect from the first rising clock edge after reset=1.

Configuration
REQ-031 Macro INSTR_QUEUE_COUNT_EN SHALL control whether occupancy is exposed.
REQ-032 With INSTR_QUEUE_COUNT_EN defined: an extra output count, PTR_W+1 bits, equals the internal occupancy, with reset value 0.
REQ-033 Without INSTR_QUEUE_COUNT_EN: the count port SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Reset low, then push 0x20080005 @0x00000000 -> one cycle later out_valid=1, out_instruction=0x20080005, out_address=0x00000000.
REQ-035 Push 4 entries @0x0, 0x4, 0x8, 0xC with out_ready=0 -> in_ready=0 after the 4th push; a 5th in_valid is ignored; draining yields 0x0, 0x4, 0x8, 0xC in order.
REQ-036 Hold in_valid=1 and out_ready=1 for 10 cycles from empty -> count stays at 1, and out_address steps 0x0, 0x4, ... with pointer wrap and no loss.
REQ-037 3 entries queued, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, count=0, and the pushed entry is dropped.
REQ-038 2 entries queued, drive reset=0 between clock edges -> out_valid=0 and out_address=0 immediately, before the next clock edge.
REQ-039 Full queue with out_ready=1 and in_valid=1 -> count goes 4 to 3; the push occurs on the following edge.
